// File: rtl/l2_flush_controller.sv
// L2 flush sequencer: accepts one flush request, waits for the MSHRs to drain,
// then walks every set/way (way-minor, set-major) issuing one flush op per line.
module l2_flush_controller #(
    parameter int unsigned L2_SETS = 256,
    parameter int unsigned L2_WAYS = 8,
    parameter int unsigned N_MSHR  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_req_valid,
    output logic                              flush_req_ready,
    input  logic [$clog2(N_MSHR+1)-1:0]       mshr_cnt,
    input  logic                              fwd_pending,
    output logic                              flush_op_valid,
    input  logic                              flush_op_ready,
    output logic [$clog2(L2_SETS)-1:0]        flush_op_set,
    output logic [$clog2(L2_WAYS)-1:0]        flush_op_way,
    output logic                              flush_op_last,
    output logic                              ongoing_flush,
    output logic                              flush_done
);

    localparam int unsigned SET_W = $clog2(L2_SETS);
    localparam int unsigned WAY_W = $clog2(L2_WAYS);
    localparam int unsigned CNT_W = $clog2(N_MSHR + 1);

    localparam logic [SET_W-1:0] SET_MAX  = SET_W'(L2_SETS - 1);
    localparam logic [WAY_W-1:0] WAY_MAX  = WAY_W'(L2_WAYS - 1);
    localparam logic [CNT_W-1:0] MSHR_ALL = CNT_W'(N_MSHR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [SET_W-1:0]  set_q;
    logic [WAY_W-1:0]  way_q;
    logic              op_xfer;
    logic              set_at_max;
    logic              way_at_max;

    // Outputs decode directly from registered state so a forward can pull
    // flush_op_valid in the same cycle it appears.
    assign flush_req_ready = (state == IDLE);
    assign ongoing_flush   = (state != IDLE);
    assign flush_done      = (state == DONE);
    assign flush_op_valid  = (state == ISSUE) && !fwd_pending;
    assign flush_op_set    = set_q;
    assign flush_op_way    = way_q;

    assign set_at_max    = (set_q == SET_MAX);
    assign way_at_max    = (way_q == WAY_MAX);
    assign flush_op_last = set_at_max && way_at_max;
    assign op_xfer       = flush_op_valid && flush_op_ready;

    // Flush sequencer: state plus the set/way walk counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            set_q <= '0;
            way_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req_valid) begin
                        state <= DRAIN;
                        set_q <= '0;
                        way_q <= '0;
                    end
                end
                DRAIN: begin
                    if (mshr_cnt == MSHR_ALL) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Counters only move on an accepted op; stalls keep set/way stable.
                    if (op_xfer) begin
                        if (!way_at_max) begin
                            way_q <= way_q + WAY_W'(1);
                        end else begin
                            way_q <= '0;
                            if (!set_at_max) begin
                                set_q <= set_q + SET_W'(1);
                            end else begin
                                set_q <= '0;
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
